pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Program-counter register and instruction-fetch sequencer for the MIPS core. It is the consumer of the next-PC value produced by the next-PC logic. It holds the current word-addressed PC and fetches the instruction at that PC from instruction memory over a request/grant/response handshake. It presents the instruction to decode until the datapath acknowledges it, then loads `next_pc` and fetches again.

## Interface
Parameters:
- `RESET_PC`, default 30'h0000_0C00 (byte address 0x0000_3000): word-addressed PC value loaded on reset.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `next_pc`  in  [31:2]  word-addressed next PC from next-PC logic; sampled only on the acknowledge cycle.
- `pc`  out  [31:2]  current PC (address of the instruction being fetched or held).
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  [31:2]  fetch address; equals `pc` whenever `imem_req`=1.
- `imem_gnt`  in  1  memory accepted the request this cycle.
- `imem_rvalid`  in  1  `imem_rdata` valid this cycle.
- `imem_rdata`  in  [31:0]  fetched instruction word.
- `instr`  out  [31:0]  held instruction to decode.
- `instr_valid`  out  1  `instr` is valid for the datapath.
- `instr_ack`  in  1  datapath has consumed `instr` and `next_pc` is final.

## Operation
- Three-state FSM:
  - **S_REQ**
    - `imem_req`=1, `imem_addr`=`pc`.
    - If `imem_gnt`=1, go to S_WAIT.
    - Otherwise stay in S_REQ. Address and request are held stable.
  - **S_WAIT**
    - `imem_req`=0.
    - If `imem_rvalid`=1, capture `imem_rdata` into `instr`, set `instr_valid`=1, and go to S_HOLD.
  - **S_HOLD**
    - `instr_valid`=1 and `instr` is stable.
    - If `instr_ack`=1, load `pc` from `next_pc`, clear `instr_valid`, and go to S_REQ.
- `instr_ack` outside S_HOLD is ignored.
- `imem_rvalid` outside S_WAIT is ignored. Memory guarantees at most one response per grant, and the response arrives no earlier than the cycle after the grant.
- `pc` changes only on reset or on an acknowledge in S_HOLD. No arithmetic is performed here, so a `next_pc` wrap from 30'h3FFF_FFFF to 0 is loaded as given.
- Reset mid-operation, i.e. `rst_n`=0 in any state:
  - FSM goes to S_REQ, `pc` is loaded with `RESET_PC`, and `instr_valid` is cleared.
  - Instruction memory shares `rst_n`, so no response is outstanding across reset.

## Timing
- Reset values:
  - state = S_REQ, `pc` = `RESET_PC`.
  - `imem_req` = 1 from the first cycle with `rst_n`=1. It is combinational from the state, so it reads 1 during reset.
  - `instr` = 32'h0000_0000, `instr_valid` = 0.
- `imem_req` and `imem_addr` are decoded from state and `pc`, so they are glitch-free registered values.
- Minimum fetch latency with zero-wait memory:
  - cycle 0: grant in S_REQ.
  - cycle 1: rvalid in S_WAIT.
  - cycle 2: `instr_valid`=1.
- Minimum acknowledge-to-next-request latency is 1 cycle: `instr_ack` at edge N gives new `pc` and `imem_req`=1 at N+1.
- Best-case throughput is one instruction per 3 cycles.

## Configuration
- `FETCH_PERF_CNT_EN`, when defined, adds two output ports:
  - `fetch_count` [31:0]: increments on each accepted `instr_ack` in S_HOLD.
  - `stall_count` [31:0]: increments on every cycle spent in S_REQ with `imem_gnt`=0, or in S_WAIT with `imem_rvalid`=0.
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Without the macro, neither port nor any counter logic exists. All other behaviour is identical.

## Test plan
- Reset release, memory granting immediately with rvalid one cycle later and rdata 32'h2008_0005 -> `imem_addr`=30'h0C00 on the first cycle, `instr`=32'h2008_0005 with `instr_valid`=1 two cycles later.
- Sequential fetch: ack with `next_pc`=30'h0C01 -> next cycle `pc`=30'h0C01 and `imem_req`=1; `instr_valid` drops the same cycle.
- Grant withheld 3 cycles, then rvalid delayed 2 cycles -> `imem_addr` held stable throughout, `instr` captured only on the rvalid cycle. With `FETCH_PERF_CNT_EN`, `stall_count`=5.
- Branch/jump target `next_pc`=30'h0C40 acked while `instr_ack` is also pulsed in S_WAIT -> the S_WAIT pulse is ignored and the fetch after the hold is from 30'h0C40.
- Ack held high continuously with spurious rvalid in S_REQ -> spurious data not captured; exactly one `pc` update per S_HOLD visit.
- `rst_n` low for one cycle while in S_HOLD with `pc`=30'h0D00 -> next cycle `pc`=30'h0C00, `instr_valid`=0, `imem_req`=1.

Source files
------------

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction-memory request/grant/response bus
//
// Groups the fetch-side memory handshake:
//   req    fetch request (fetch unit -> memory)
//   addr   word address [31:2] (fetch unit -> memory)
//   gnt    request accepted this cycle (memory -> fetch unit)
//   rvalid rdata valid this cycle (memory -> fetch unit)
//   rdata  fetched instruction word (memory -> fetch unit)
// master = fetch unit side, slave = instruction memory side.

interface pc_fetch_unit_if;
   logic        req;
   logic [31:2] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rvalid,
      output rdata
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter register and instruction fetch sequencer
//
// Holds the word-addressed PC, fetches the instruction at PC over the imem
// bus, presents it to decode until acknowledged, then loads next_pc.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   imem         pc_fetch_unit_if.master (req/addr out, gnt/rvalid/rdata in)
//   next_pc      [31:2] next PC, sampled only on an accepted acknowledge
//   pc           [31:2] current PC
//   instr        [31:0] held instruction
//   instr_valid  instr is valid for the datapath
//   instr_ack    datapath consumed instr and next_pc is final
//
// Optional feature macro FETCH_PERF_CNT_EN adds:
//   fetch_count  [31:0] accepted acknowledges (saturating)
//   stall_count  [31:0] cycles waiting on grant or response (saturating)

module pc_fetch_unit #(
   parameter logic [31:2] RESET_PC = 30'h0000_0C00
) (
   input  logic                   clk,
   input  logic                   rst_n,
   pc_fetch_unit_if.master        imem,
   input  logic [31:2]            next_pc,
   output logic [31:2]            pc,
   output logic [31:0]            instr,
   output logic                   instr_valid,
   input  logic                   instr_ack
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]            fetch_count,
   output logic [31:0]            stall_count
`endif
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:2] pc_q;
   logic [31:0] instr_q;
   logic        instr_valid_q;
   logic        capture;
   logic        load_pc;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= S_REQ;
         pc_q          <= RESET_PC;
         instr_q       <= 32'h0000_0000;
         instr_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_pc) begin
            pc_q          <= next_pc;
            instr_valid_q <= 1'b0;
         end
         if (capture) begin
            instr_q       <= imem.rdata;
            instr_valid_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      load_pc = 1'b0;
      case (state_q)
         S_REQ: begin
            if (imem.gnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem.rvalid) begin
               capture = 1'b1;
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            if (instr_ack) begin
               load_pc = 1'b1;
               state_d = S_REQ;
            end
         end
         default: state_d = S_REQ;
      endcase
   end

   // Request and address come straight from registered state, so they are
   // stable for the whole cycle and held while the grant is withheld.
   assign imem.req    = (state_q == S_REQ);
   assign imem.addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q;
   logic [31:0] stall_cnt_q;
   logic        stall;

   assign stall = ((state_q == S_REQ)  && !imem.gnt) ||
                  ((state_q == S_WAIT) && !imem.rvalid);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_cnt_q <= 32'h0000_0000;
         stall_cnt_q <= 32'h0000_0000;
      end else begin
         if (load_pc && (fetch_cnt_q != 32'hFFFF_FFFF))
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
         if (stall && (stall_cnt_q != 32'hFFFF_FFFF))
            stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end

   assign fetch_count = fetch_cnt_q;
   assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - self-checking bench for pc_fetch_unit

module tb_pc_fetch_unit;

   localparam logic [31:2] RST_PC = 30'h0000_0C00;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:2] next_pc;
   logic [31:2] pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic        instr_ack;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_count;
   logic [31:0] stall_count;
`endif

   pc_fetch_unit_if bus ();

   pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem        (bus),
      .next_pc     (next_pc),
      .pc          (pc),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ack   (instr_ack)
`ifdef FETCH_PERF_CNT_EN
      ,
      .fetch_count (fetch_count),
      .stall_count (stall_count)
`endif
   );

   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Transaction-level reference: a fetch is either awaiting a grant, granted
   // and awaiting data, or delivered and awaiting acknowledge.
   logic [31:2] m_pc;
   logic [31:0] m_instr;
   logic        m_granted;
   logic        m_have;
   logic [31:0] m_fetch;
   logic [31:0] m_stall;

   function automatic logic m_req();
      return !m_granted && !m_have;
   endfunction

   task automatic cycle(input logic r, input logic g, input logic v, input logic [31:0] d,
                        input logic a, input logic [31:2] np);
      rst_n      = r;
      bus.gnt    = g;
      bus.rvalid = v;
      bus.rdata  = d;
      instr_ack  = a;
      next_pc    = np;
      @(posedge clk);
      if (!r) begin
         m_pc = RST_PC; m_instr = 32'h0; m_granted = 1'b0; m_have = 1'b0;
         m_fetch = 32'h0; m_stall = 32'h0;
      end else if (m_have) begin
         if (a) begin
            m_pc = np;
            m_have = 1'b0;
            if (m_fetch != 32'hFFFF_FFFF) m_fetch++;
         end
      end else if (m_granted) begin
         if (v) begin
            m_instr = d; m_have = 1'b1; m_granted = 1'b0;
         end else if (m_stall != 32'hFFFF_FFFF) m_stall++;
      end else begin
         if (g) m_granted = 1'b1;
         else if (m_stall != 32'hFFFF_FFFF) m_stall++;
      end
      #1;
      chk("pc", {2'b00, pc}, {2'b00, m_pc});
      chk("imem_req", {31'h0, bus.req}, {31'h0, m_req()});
      if (m_req()) chk("imem_addr", {2'b00, bus.addr}, {2'b00, m_pc});
      chk("instr", instr, m_instr);
      chk("instr_valid", {31'h0, instr_valid}, {31'h0, m_have});
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", fetch_count, m_fetch);
      chk("stall_count", stall_count, m_stall);
`endif
   endtask

   // Memory side of the random phase.
   logic       mem_busy;
   int         mem_lat;

   initial begin
      logic        g, v, a, r, req_pre;
      logic [31:0] d;
      logic [31:2] np;

      m_pc = RST_PC; m_instr = 0; m_granted = 0; m_have = 0; m_fetch = 0; m_stall = 0;
      bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0; instr_ack = 0; next_pc = 0; rst_n = 0;

      // Reset: request visible during reset with the reset PC.
      cycle(0, 0, 0, 32'h0, 0, 30'h0);
      cycle(0, 0, 0, 32'h0, 0, 30'h0);
      chk("rst_req", {31'h0, bus.req}, 32'h1);
      chk("rst_addr", {2'b00, bus.addr}, {2'b00, 30'h0C00});
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);

      // Zero-wait fetch.
      cycle(1, 1, 0, 32'h0, 0, 30'h0);
      cycle(1, 0, 1, 32'h2008_0005, 0, 30'h0);
      chk("tp1_instr", instr, 32'h2008_0005);
      chk("tp1_valid", {31'h0, instr_valid}, 32'h1);

      // Sequential acknowledge.
      cycle(1, 0, 0, 32'h0, 1, 30'h0C01);
      chk("tp2_pc", {2'b00, pc}, {2'b00, 30'h0C01});
      chk("tp2_req", {31'h0, bus.req}, 32'h1);
      chk("tp2_valid", {31'h0, instr_valid}, 32'h0);

      // Grant withheld 3 cycles, response delayed 2 cycles.
      for (int i = 0; i < 3; i++) cycle(1, 0, 0, $urandom, 0, 30'h0);
      cycle(1, 1, 0, $urandom, 0, 30'h0);
      for (int i = 0; i < 2; i++) cycle(1, 0, 0, $urandom, 0, 30'h0);
      cycle(1, 0, 1, 32'h1234_5678, 0, 30'h0);
      chk("tp3_instr", instr, 32'h1234_5678);
`ifdef FETCH_PERF_CNT_EN
      chk("tp3_stall", stall_count, 32'd5);
`endif

      // Branch target with an ignored ack pulse in the wait state.
      cycle(1, 0, 0, 32'h0, 1, 30'h0C02);
      cycle(1, 1, 0, 32'h0, 0, 30'h0);
      cycle(1, 0, 0, 32'h0, 1, 30'h1111);
      chk("tp4_pc_hold", {2'b00, pc}, {2'b00, 30'h0C02});
      cycle(1, 0, 1, 32'hAAAA_0001, 0, 30'h0);
      cycle(1, 0, 0, 32'h0, 1, 30'h0C40);
      chk("tp4_addr", {2'b00, bus.addr}, {2'b00, 30'h0C40});

      // Ack held high, spurious rvalid while requesting.
      cycle(1, 0, 1, 32'hDEAD_BEEF, 1, 30'h2222);
      cycle(1, 1, 1, 32'hDEAD_BEE0, 1, 30'h2222);
      cycle(1, 0, 1, 32'h0BAD_F00D, 1, 30'h2222);
      cycle(1, 0, 0, 32'h0, 1, 30'h0D00);
      chk("tp5_pc", {2'b00, pc}, {2'b00, 30'h0D00});

      // Reset while holding with pc 0x0D00.
      cycle(1, 1, 0, 32'h0, 1, 30'h3333);
      cycle(1, 0, 1, 32'hCAFE_0000, 1, 30'h3333);
      chk("tp6_pre_pc", {2'b00, pc}, {2'b00, 30'h0D00});
      cycle(0, 0, 0, 32'h0, 0, 30'h0);
      chk("tp6_pc", {2'b00, pc}, {2'b00, 30'h0C00});
      chk("tp6_valid", {31'h0, instr_valid}, 32'h0);
      chk("tp6_req", {31'h0, bus.req}, 32'h1);

      // Random traffic against the reference.
      mem_busy = 0; mem_lat = 0;
      for (int n = 0; n < 3000; n++) begin
         r  = ($urandom_range(0, 99) != 0);
         req_pre = m_req();
         g  = req_pre ? ($urandom_range(0, 2) != 0) : 1'b0;
         d  = $urandom;
         if (mem_busy) v = (mem_lat == 0);
         else          v = ($urandom_range(0, 7) == 0);
         a  = ($urandom_range(0, 1) == 1);
         np = ($urandom_range(0, 15) == 0) ? 30'h3FFF_FFFF : 30'($urandom);
         cycle(r, g, v, d, a, np);
         if (!r) mem_busy = 0;
         else if (mem_busy && v) mem_busy = 0;
         else if (mem_busy) mem_lat--;
         else if (g && req_pre) begin
            mem_busy = 1;
            mem_lat  = $urandom_range(0, 2);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
